// File: rtl/cpu_core_pkg.sv
// Shared definitions for the accumulator CPU: widths, opcodes, FSM states
// and the immediate sign-extension helper.
package cpu_core_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 16;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDA  = 4'h1;
   localparam logic [3:0] OP_STA  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;
   localparam logic [3:0] OP_LDI  = 4'h8;
   localparam logic [3:0] OP_ADDI = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_JZ   = 4'hB;
   localparam logic [3:0] OP_JN   = 4'hC;
   localparam logic [3:0] OP_SHL  = 4'hD;
   localparam logic [3:0] OP_SHR  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_HALT
   } state_t;

   // 16-bit immediate widened to the accumulator width, sign preserved
   function automatic logic signed [DATA_W-1:0] sext_imm(input logic [ADDR_W-1:0] imm);
      return {{(DATA_W-ADDR_W){imm[ADDR_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational accumulator ALU. The operand is either the memory word
// (LDA and ALU-memory ops) or the sign-extended immediate (LDI/ADDI).
module cpu_alu
   import cpu_core_pkg::*;
(
   input  logic [3:0]        i_opcode,
   input  logic [DATA_W-1:0] i_acc,
   input  logic [DATA_W-1:0] i_opnd,
   output logic [DATA_W-1:0] o_result
);

   logic signed [DATA_W-1:0] w_a;
   logic signed [DATA_W-1:0] w_b;

   assign w_a = i_acc;
   assign w_b = i_opnd;

   // Result select; unknown or non-ALU opcodes leave the accumulator unchanged
   always_comb begin
      o_result = i_acc;
      case (i_opcode)
         OP_LDA,
         OP_LDI:  o_result = w_b;
         OP_ADD,
         OP_ADDI: o_result = w_a + w_b;
         OP_SUB:  o_result = w_a - w_b;
         OP_AND:  o_result = i_acc & i_opnd;
         OP_OR:   o_result = i_acc | i_opnd;
         OP_XOR:  o_result = i_acc ^ i_opnd;
         OP_SHL:  o_result = {i_acc[DATA_W-2:0], 1'b0};
         OP_SHR:  o_result = {1'b0, i_acc[DATA_W-1:1]};
         default: o_result = i_acc;
      endcase
   end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle accumulator CPU. FETCH/DECODE/EXEC[/MEM] sequence, one memory
// access in flight, all traffic through the registered MAR/MBR_W/write.
module cpu_core
   import cpu_core_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] MAR,
   output logic [31:0] MBR_W,
   output logic        write,
   input  logic [31:0] MBR_R
);

   state_t                   r_state;
   state_t                   w_nxt_state;
   logic [ADDR_W-1:0]        r_pc;
   logic [ADDR_W-1:0]        w_nxt_pc;
   logic [ADDR_W-1:0]        r_mar;
   logic [ADDR_W-1:0]        w_nxt_mar;
   logic signed [DATA_W-1:0] r_acc;
   logic signed [DATA_W-1:0] w_nxt_acc;
   logic [DATA_W-1:0]        r_ir;
   logic [DATA_W-1:0]        w_nxt_ir;
   logic [DATA_W-1:0]        r_mbr_w;
   logic [DATA_W-1:0]        w_nxt_mbr_w;
   logic                     r_write;
   logic                     w_nxt_write;

   logic [3:0]               w_opcode;
   logic [ADDR_W-1:0]        w_addr;
   logic [DATA_W-1:0]        w_alu_opnd;
   logic [DATA_W-1:0]        w_alu_res;
   logic                     w_ir_unused;

   assign w_opcode    = r_ir[31:28];
   assign w_addr      = r_ir[15:0];
   assign w_ir_unused = ^r_ir[27:16];

   // In MEM the operand is the word just read; in EXEC it is the immediate
   assign w_alu_opnd = (r_state == ST_MEM) ? MBR_R : sext_imm(w_addr);

   cpu_alu u_alu (
      .i_opcode (w_opcode),
      .i_acc    (r_acc),
      .i_opnd   (w_alu_opnd),
      .o_result (w_alu_res)
   );

   assign MAR   = r_mar;
   assign MBR_W = r_mbr_w;
   assign write = r_write;

   // State and architectural registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_FETCH;
         r_pc    <= '0;
         r_acc   <= '0;
         r_ir    <= '0;
         r_mar   <= '0;
         r_mbr_w <= '0;
         r_write <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_pc    <= w_nxt_pc;
         r_acc   <= w_nxt_acc;
         r_ir    <= w_nxt_ir;
         r_mar   <= w_nxt_mar;
         r_mbr_w <= w_nxt_mbr_w;
         r_write <= w_nxt_write;
      end
   end

   // Next-state and next-register values; write is a one-cycle pulse by default
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_pc    = r_pc;
      w_nxt_acc   = r_acc;
      w_nxt_ir    = r_ir;
      w_nxt_mar   = r_mar;
      w_nxt_mbr_w = r_mbr_w;
      w_nxt_write = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_nxt_mar   = r_pc;
            w_nxt_state = ST_DECODE;
         end
         ST_DECODE: begin
            w_nxt_ir    = MBR_R;
            w_nxt_pc    = r_pc + 1'b1;
            w_nxt_state = ST_EXEC;
         end
         ST_EXEC: begin
            w_nxt_state = ST_FETCH;
            case (w_opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                  w_nxt_mar   = w_addr;
                  w_nxt_state = ST_MEM;
               end
               OP_STA: begin
                  w_nxt_mar   = w_addr;
                  w_nxt_mbr_w = r_acc;
                  w_nxt_write = 1'b1;
                  w_nxt_state = ST_MEM;
               end
               OP_LDI, OP_ADDI, OP_SHL, OP_SHR: w_nxt_acc = w_alu_res;
               OP_JMP:  w_nxt_pc = w_addr;
               OP_JZ:   if (r_acc == 0) w_nxt_pc = w_addr;
               OP_JN:   if (r_acc < 0)  w_nxt_pc = w_addr;
               OP_HALT: w_nxt_state = ST_HALT;
               default: w_nxt_state = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            if (w_opcode != OP_STA) w_nxt_acc = w_alu_res;
            w_nxt_state = ST_FETCH;
         end
         ST_HALT: w_nxt_state = ST_HALT;
         default: w_nxt_state = ST_FETCH;
      endcase
   end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: small programs in a local unified memory,
// outputs sampled on the falling edge at hand-counted cycles.
module tb_cpu_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] MAR;
   logic [31:0] MBR_W;
   logic        write;
   logic [31:0] MBR_R;

   logic [31:0] mem [0:65535];
   logic        tb_we = 1'b0;
   logic [15:0] tb_addr = '0;
   logic [31:0] tb_data = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int wr_base = 0;

   always #5 clk = ~clk;

   cpu_core dut (
      .clk   (clk),
      .reset (reset),
      .MAR   (MAR),
      .MBR_W (MBR_W),
      .write (write),
      .MBR_R (MBR_R)
   );

   assign MBR_R = mem[MAR];

   // Memory: CPU writes take priority; bench loads only happen under reset
   always @(posedge clk) begin
      if (write) begin
         mem[MAR] <= MBR_W;
         wr_cnt   <= wr_cnt + 1;
      end else if (tb_we) begin
         mem[tb_addr] <= tb_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic ld(input logic [15:0] a, input logic [31:0] d);
      tb_addr = a;
      tb_data = d;
      tb_we   = 1'b1;
      @(negedge clk);
      tb_we   = 1'b0;
   endtask

   task automatic hold_reset();
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic release_reset();
      reset   = 1'b0;
      cyc     = 0;
      wr_base = wr_cnt;
   endtask

   // Advance to the falling edge after the n-th rising edge since release
   task automatic go(input int n);
      while (cyc < n) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   initial begin
      // ---- reset state and load/add/store program ----
      hold_reset();
      ld(16'h0000, 32'h8000_0005);
      ld(16'h0001, 32'h3000_0010);
      ld(16'h0002, 32'h2000_0011);
      ld(16'h0003, 32'hF000_0000);
      ld(16'h0010, 32'h0000_0007);
      ld(16'h0011, 32'h0000_0000);
      chk("rst_mar", {16'h0, MAR}, 32'h0);
      chk("rst_write", {31'h0, write}, 32'h0);
      chk("rst_mbrw", MBR_W, 32'h0);
      release_reset();
      go(1);  chk("p1_fetch0", {16'h0, MAR}, 32'h0);
      go(4);  chk("p1_fetch1", {16'h0, MAR}, 32'h1);
      go(6);  chk("p1_add_mar", {16'h0, MAR}, 32'h10);
      go(8);  chk("p1_fetch2", {16'h0, MAR}, 32'h2);
      go(10);
      chk("p1_sta_wr", {31'h0, write}, 32'h1);
      chk("p1_sta_mar", {16'h0, MAR}, 32'h11);
      chk("p1_sta_data", MBR_W, 32'd12);
      go(11); chk("p1_wr_drop", {31'h0, write}, 32'h0);
      go(12); chk("p1_fetch3", {16'h0, MAR}, 32'h3);
      go(40);
      chk("p1_halt_mar", {16'h0, MAR}, 32'h3);
      chk("p1_mem11", mem[16'h0011], 32'd12);
      chk("p1_wr_count", wr_cnt - wr_base, 32'd1);

      // ---- sign extension, wrap to zero, taken JZ ----
      hold_reset();
      ld(16'h0000, 32'h8000_FFFF);
      ld(16'h0001, 32'h2000_0040);
      ld(16'h0002, 32'h9000_0001);
      ld(16'h0003, 32'hB000_0020);
      ld(16'h0020, 32'h2000_0041);
      ld(16'h0021, 32'hF000_0000);
      release_reset();
      go(6);
      chk("p2_ldi_sext", MBR_W, 32'hFFFF_FFFF);
      chk("p2_sta_mar", {16'h0, MAR}, 32'h40);
      go(14); chk("p2_jz_taken", {16'h0, MAR}, 32'h20);
      go(16);
      chk("p2_addi_wrap", MBR_W, 32'h0);
      chk("p2_sta2_wr", {31'h0, write}, 32'h1);
      go(30); chk("p2_mem40", mem[16'h0040], 32'hFFFF_FFFF);

      // ---- JN not taken, SHL, SHR ----
      hold_reset();
      ld(16'h0000, 32'h8000_0001);
      ld(16'h0001, 32'hC000_0030);
      ld(16'h0002, 32'hD000_0000);
      ld(16'h0003, 32'h2000_0042);
      ld(16'h0004, 32'h1000_0050);
      ld(16'h0005, 32'hE000_0000);
      ld(16'h0006, 32'h2000_0043);
      ld(16'h0007, 32'hF000_0000);
      ld(16'h0050, 32'h8000_0000);
      release_reset();
      go(7);  chk("p3_jn_not", {16'h0, MAR}, 32'h2);
      go(12);
      chk("p3_shl", MBR_W, 32'h2);
      chk("p3_shl_mar", {16'h0, MAR}, 32'h42);
      go(23);
      chk("p3_shr", MBR_W, 32'h4000_0000);
      chk("p3_shr_wr", {31'h0, write}, 32'h1);

      // ---- SUB / OR / AND / XOR chain ----
      hold_reset();
      ld(16'h0000, 32'h8000_0010);
      ld(16'h0001, 32'h4000_0060);
      ld(16'h0002, 32'h6000_0061);
      ld(16'h0003, 32'h5000_0062);
      ld(16'h0004, 32'h7000_0063);
      ld(16'h0005, 32'h2000_0045);
      ld(16'h0006, 32'hF000_0000);
      ld(16'h0060, 32'h0000_000F);
      ld(16'h0061, 32'h0000_00F0);
      ld(16'h0062, 32'h0000_00F3);
      ld(16'h0063, 32'h0000_00FF);
      release_reset();
      go(22);
      chk("p4_alu_chain", MBR_W, 32'h0000_000E);
      chk("p4_sta_mar", {16'h0, MAR}, 32'h45);

      // ---- reset during the MEM cycle of STA ----
      hold_reset();
      ld(16'h0000, 32'h8000_0077);
      ld(16'h0001, 32'h2000_0044);
      ld(16'h0002, 32'hA000_0002);
      ld(16'h0044, 32'h0000_0000);
      release_reset();
      go(6);  chk("p5_sta_wr", {31'h0, write}, 32'h1);
      reset = 1'b1;
      @(negedge clk);
      chk("p5_store_landed", mem[16'h0044], 32'h77);
      chk("p5_rst_mar", {16'h0, MAR}, 32'h0);
      chk("p5_rst_write", {31'h0, write}, 32'h0);
      release_reset();
      go(1);  chk("p5_restart0", {16'h0, MAR}, 32'h0);
      go(4);  chk("p5_restart1", {16'h0, MAR}, 32'h1);
      go(11); chk("p5_jmp_self", {16'h0, MAR}, 32'h2);
      go(14); chk("p5_jmp_loop", {16'h0, MAR}, 32'h2);

      // ---- PC wrap at 0xFFFF ----
      hold_reset();
      ld(16'h0000, 32'hA000_FFFF);
      ld(16'hFFFF, 32'h0000_0000);
      release_reset();
      go(4);  chk("p6_fetch_ffff", {16'h0, MAR}, 32'hFFFF);
      go(7);  chk("p6_wrap0", {16'h0, MAR}, 32'h0);
      go(10); chk("p6_again_ffff", {16'h0, MAR}, 32'hFFFF);
      chk("p6_no_writes", wr_cnt - wr_base, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
